// File: rtl/sram_like_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_bridge_pkg: shared encodings and helpers for the sram-like bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_tag_fifo.sv
// ---------------------------------------------------------------------------
// sram_like_tag_fifo: in-order FIFO of channel ids for outstanding requests
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_like_tag_fifo
  import sram_like_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [ID_W-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [ID_W-1:0]  mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_bridge.sv
// ---------------------------------------------------------------------------
// sram_like_bridge: merges NUM_CH sram-like channels onto one shared bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int TRANSLATE = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     req,
  output logic                     wr,
  output logic [1:0]               size,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        wdata,
  output logic                     uncached,
  input  logic                     addr_ok,
  input  logic                     data_ok,
  input  logic [DATA_W-1:0]        rdata,
  output logic                     err_spurious
);

  localparam int ID_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  lock_state_e      lock_state;
  lock_state_e      lock_next;
  logic [ID_W-1:0]  lock_id;
  logic [ID_W-1:0]  lock_id_next;
  logic [ID_W-1:0]  req_id;
  logic [ID_W-1:0]  grant;
  logic             any_req;
  logic             locked;
  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W-1:0]  head_id;
  logic [ADDR_W-1:0] vaddr;

  // Fixed priority: lowest index wins, so scan from the top down.
  always_comb begin
    req_id  = '0;
    any_req = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        req_id  = ID_W'(i);
        any_req = 1'b1;
      end
    end
  end

  assign locked = (lock_state == LOCK_HELD);
  assign grant  = locked ? lock_id : req_id;
  assign req    = resetn & (any_req | locked) & ~fifo_full;
  assign accept = req & addr_ok;
  assign pop    = resetn & data_ok & ~fifo_empty;

  always_comb begin
    wr    = ch_wr[0];
    size  = ch_size[1:0];
    vaddr = ch_addr[ADDR_W-1:0];
    wdata = ch_wdata[DATA_W-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == ID_W'(i)) begin
        wr    = ch_wr[i];
        size  = ch_size[2*i +: 2];
        vaddr = ch_addr[ADDR_W*i +: ADDR_W];
        wdata = ch_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  generate
    if (TRANSLATE != 0) begin : g_translate
      always_comb begin
        addr     = vaddr;
        uncached = 1'b0;
        if (vaddr[ADDR_W-1 -: 3] == KSEG0) begin
          addr[ADDR_W-1 -: 3] = 3'b000;
        end else if (vaddr[ADDR_W-1 -: 3] == KSEG1) begin
          addr[ADDR_W-1 -: 3] = 3'b000;
          uncached            = 1'b1;
        end
      end
    end else begin : g_identity
      assign addr     = vaddr;
      assign uncached = 1'b0;
    end
  endgenerate

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && (grant == ID_W'(i))) begin
        ch_addr_ok[i] = 1'b1;
      end
      if (pop && (head_id == ID_W'(i))) begin
        ch_data_ok[i] = 1'b1;
      end
    end
  end

  assign ch_rdata = rdata;

  // The lock pins the grant while the bus has not yet taken the request.
  always_comb begin
    lock_next    = lock_state;
    lock_id_next = lock_id;
    case (lock_state)
      LOCK_IDLE: begin
        if (req && !addr_ok) begin
          lock_next    = LOCK_HELD;
          lock_id_next = grant;
        end
      end
      LOCK_HELD: begin
        if (accept) begin
          lock_next = LOCK_IDLE;
        end
      end
      default: lock_next = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_state   <= LOCK_IDLE;
      lock_id      <= '0;
      err_spurious <= 1'b0;
    end else begin
      lock_state <= lock_next;
      lock_id    <= lock_id_next;
      if (data_ok && fifo_empty) begin
        err_spurious <= 1'b1;
      end
    end
  end

  sram_like_tag_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_like_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_like_bridge: table-driven and scoreboard bench for sram_like_bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_like_bridge;
  import sram_like_bridge_pkg::*;

  localparam logic [31:0] A0 = 32'h8000_1000;
  localparam logic [31:0] A1 = 32'hA000_3000;
  localparam logic [31:0] W0 = 32'h0000_00AA;
  localparam logic [31:0] W1 = 32'h1111_0001;
  localparam logic [3:0]  SZ_WW = {SIZE_WORD, SIZE_WORD};

  typedef struct {
    logic [1:0]  rq;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  sz;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_unc;
    logic        e_wr;
    logic [1:0]  e_size;
    int          e_ch;
    logic [1:0]  e_aok;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  ch_req;
  logic [1:0]  ch_wr;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [1:0]  ch_addr_ok;
  logic [1:0]  ch_data_ok;
  logic [31:0] ch_rdata;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        uncached;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err_spurious;

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];
  int   sb[$];

  always #5 clk = ~clk;

  sram_like_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .ch_req       (ch_req),
    .ch_wr        (ch_wr),
    .ch_size      (ch_size),
    .ch_addr      (ch_addr),
    .ch_wdata     (ch_wdata),
    .ch_addr_ok   (ch_addr_ok),
    .ch_data_ok   (ch_data_ok),
    .ch_rdata     (ch_rdata),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .uncached     (uncached),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .err_spurious (err_spurious)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] rq, input logic [1:0] w, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [3:0] sz, input logic aok,
                     input logic dok, input logic [31:0] rd, input logic e_req,
                     input logic [31:0] e_addr, input logic e_unc, input logic e_wr,
                     input logic [1:0] e_size, input int e_ch, input logic [1:0] e_aok);
    vec_t v;
    v.rq = rq; v.wr = w; v.a0 = a0; v.a1 = a1; v.sz = sz; v.aok = aok; v.dok = dok;
    v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_unc = e_unc; v.e_wr = e_wr;
    v.e_size = e_size; v.e_ch = e_ch; v.e_aok = e_aok;
    vq.push_back(v);
  endtask

  task automatic idle_dok(input logic [31:0] rd);
    add(2'b00, 2'b00, A0, A1, SZ_WW, 1'b0, 1'b1, rd, 1'b0, 32'h0, 1'b0, 1'b0, SIZE_WORD, 0, 2'b00);
  endtask

  task automatic ch0_word(input logic aok, input logic e_req, input logic [1:0] e_aok);
    add(2'b01, 2'b00, A0, A1, SZ_WW, aok, 1'b0, 32'h0, e_req, 32'h0000_1000, 1'b0, 1'b0,
        SIZE_WORD, 0, e_aok);
  endtask

  // Expected response owner is taken from the scoreboard before any same-cycle push.
  task automatic apply(input vec_t v, input int idx);
    logic [1:0] e_dok;
    int h;
    ch_req   = v.rq;
    ch_wr    = v.wr;
    ch_addr  = {v.a1, v.a0};
    ch_size  = v.sz;
    addr_ok  = v.aok;
    data_ok  = v.dok;
    rdata    = v.rd;
    e_dok    = 2'b00;
    if (v.dok && sb.size() > 0) begin
      h     = sb.pop_front();
      e_dok = (h == 1) ? 2'b10 : 2'b01;
    end
    if (v.e_aok != 2'b00) sb.push_back(v.e_aok[1] ? 1 : 0);
    #2;
    chk($sformatf("v%0d req", idx), 32'(req), 32'(v.e_req));
    chk($sformatf("v%0d ch_addr_ok", idx), 32'(ch_addr_ok), 32'(v.e_aok));
    chk($sformatf("v%0d ch_data_ok", idx), 32'(ch_data_ok), 32'(e_dok));
    chk($sformatf("v%0d ch_rdata", idx), ch_rdata, v.rd);
    chk($sformatf("v%0d err_spurious", idx), 32'(err_spurious), 32'h0);
    if (v.e_req) begin
      chk($sformatf("v%0d addr", idx), addr, v.e_addr);
      chk($sformatf("v%0d uncached", idx), 32'(uncached), 32'(v.e_unc));
      chk($sformatf("v%0d wr", idx), 32'(wr), 32'(v.e_wr));
      chk($sformatf("v%0d size", idx), 32'(size), 32'(v.e_size));
      chk($sformatf("v%0d wdata", idx), wdata, (v.e_ch == 1) ? W1 : W0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ch_req = 2'b00; ch_wr = 2'b00; ch_addr = {A1, A0}; ch_size = SZ_WW;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
  endtask

  initial begin
    ch_wdata = {W1, W0};
    resetn   = 1'b0;
    ch_req = 2'b11; ch_wr = 2'b00; ch_addr = {A1, A0}; ch_size = SZ_WW;
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0;
    #2;
    chk("reset req", 32'(req), 32'h0);
    chk("reset ch_addr_ok", 32'(ch_addr_ok), 32'h0);
    chk("reset ch_data_ok", 32'(ch_data_ok), 32'h0);
    chk("reset err_spurious", 32'(err_spurious), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    set_idle();
    resetn = 1'b1;
    @(posedge clk); #1;

    // single read, kseg0
    ch0_word(1'b1, 1'b1, 2'b01);
    add(2'b00, 2'b00, A0, A1, SZ_WW, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, SIZE_WORD, 0, 2'b00);
    add(2'b00, 2'b00, A0, A1, SZ_WW, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, SIZE_WORD, 0, 2'b00);
    idle_dok(32'hDEAD_BEEF);
    // both channels: ch0 first, then ch1 (kseg1)
    add(2'b11, 2'b00, 32'h0000_2000, A1, SZ_WW, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, SIZE_WORD, 0, 2'b01);
    add(2'b10, 2'b00, 32'h0000_2000, A1, SZ_WW, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, SIZE_WORD, 1, 2'b10);
    idle_dok(32'h1111_1111);
    idle_dok(32'h2222_2222);
    // lock on ch1 while ch0 joins
    add(2'b10, 2'b00, A0, A1, SZ_WW, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, SIZE_WORD, 1, 2'b00);
    add(2'b11, 2'b00, A0, A1, SZ_WW, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, SIZE_WORD, 1, 2'b00);
    add(2'b11, 2'b00, A0, A1, SZ_WW, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, SIZE_WORD, 1, 2'b00);
    add(2'b11, 2'b00, A0, A1, SZ_WW, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, SIZE_WORD, 1, 2'b10);
    ch0_word(1'b1, 1'b1, 2'b01);
    idle_dok(32'h3333_3333);
    idle_dok(32'h4444_4444);
    // fill to DEPTH, blocked while full, pop frees a slot for the next cycle
    for (int i = 0; i < 4; i++) ch0_word(1'b1, 1'b1, 2'b01);
    ch0_word(1'b1, 1'b0, 2'b00);
    add(2'b01, 2'b00, A0, A1, SZ_WW, 1'b1, 1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 1'b0, SIZE_WORD, 0, 2'b00);
    ch0_word(1'b1, 1'b1, 2'b01);
    ch0_word(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) idle_dok(32'h6000_0000 + 32'(i));
    // kseg1 word write, kseg0 byte write on ch1, kuseg half read
    add(2'b01, 2'b01, 32'hBFC0_0004, A1, SZ_WW, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1FC0_0004, 1'b1, 1'b1, SIZE_WORD, 0, 2'b01);
    idle_dok(32'h7777_7777);
    add(2'b10, 2'b10, A0, 32'h9000_0001, {SIZE_BYTE, SIZE_WORD}, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1000_0001, 1'b0, 1'b1, SIZE_BYTE, 1, 2'b10);
    idle_dok(32'h8888_8888);
    add(2'b01, 2'b00, 32'h1234_5676, A1, {SIZE_WORD, SIZE_HALF}, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5676, 1'b0, 1'b0, SIZE_HALF, 0, 2'b01);
    idle_dok(32'h9999_9999);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);

    // spurious response with empty FIFO
    set_idle();
    data_ok = 1'b1;
    #2;
    chk("spurious ch_data_ok", 32'(ch_data_ok), 32'h0);
    @(posedge clk); #1;
    data_ok = 1'b0;
    #2;
    chk("spurious set", 32'(err_spurious), 32'h1);
    @(posedge clk); @(posedge clk); #1;
    chk("spurious sticky", 32'(err_spurious), 32'h1);

    // reset with one outstanding tag
    ch_req = 2'b01; addr_ok = 1'b1;
    #2;
    chk("pre-reset accept", 32'(ch_addr_ok), 32'h1);
    @(posedge clk); #2;
    resetn = 1'b0;
    data_ok = 1'b1;
    #1;
    chk("async clear err_spurious", 32'(err_spurious), 32'h0);
    chk("in reset req", 32'(req), 32'h0);
    chk("in reset ch_addr_ok", 32'(ch_addr_ok), 32'h0);
    chk("in reset ch_data_ok", 32'(ch_data_ok), 32'h0);
    @(posedge clk); #1;
    set_idle();
    resetn = 1'b1;
    data_ok = 1'b1;
    #2;
    chk("late data_ok ch_data_ok", 32'(ch_data_ok), 32'h0);
    @(posedge clk); #1;
    data_ok = 1'b0;
    #1;
    chk("late data_ok spurious", 32'(err_spurious), 32'h1);

    // count restarted at zero: exactly DEPTH accepts fit
    ch_req = 2'b01; addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("post-reset accept %0d", i), 32'(ch_addr_ok), 32'h1);
      @(posedge clk); #1;
    end
    chk("post-reset full", 32'(req), 32'h0);
    set_idle();
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
